// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and HI/LO result bus between the datapath and muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] num_1;
    logic [WIDTH-1:0] num_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output start, op, num_1, num_2,
        input  busy, done, hi, lo, zero, div_by_zero
    );
    modport slave (
        input  start, op, num_1, num_2,
        output busy, done, hi, lo, zero, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers, WIDTH+2 cycle latency.
// Define MULDIV_SIGNED_EN for two's-complement MULT/DIV; otherwise op[0] is ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   w_hi, w_lo, mag;
    logic               op_div, dbz, neg_q, neg_r;
    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, hi_fix, lo_fix;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               zero_q, dbz_q, done_q;

`ifdef MULDIV_SIGNED_EN
    assign s1 = bus.op[0] & bus.num_1[WIDTH-1];
    assign s2 = bus.op[0] & bus.num_2[WIDTH-1];
`else
    logic unused_op0;
    assign unused_op0 = bus.op[0];
    assign s1 = 1'b0;
    assign s2 = 1'b0;
`endif

    // Most-negative input negates to itself, which reads correctly as unsigned 2^(W-1).
    assign mag1 = s1 ? -bus.num_1 : bus.num_1;
    assign mag2 = s2 ? -bus.num_2 : bus.num_2;

    // w_lo holds multiplier (mult) or dividend (div); mag is the multiplicand or divisor.
    assign mul_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, mag} : '0);
    assign div_diff = {1'b0, w_hi, w_lo[WIDTH-1]} - {2'b00, mag};

    assign prod_fix = neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign q_fix    = dbz ? '1 : (neg_q ? -w_lo : w_lo);
    assign r_fix    = neg_r ? -w_hi : w_hi;
    assign hi_fix   = op_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_fix   = op_div ? q_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            w_hi   <= '0;
            w_lo   <= '0;
            mag    <= '0;
            op_div <= 1'b0;
            dbz    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            zero_q <= 1'b1;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cnt    <= '0;
                    w_hi   <= '0;
                    w_lo   <= bus.op[1] ? mag1 : mag2;
                    mag    <= bus.op[1] ? mag2 : mag1;
                    op_div <= bus.op[1];
                    dbz    <= bus.op[1] && (bus.num_2 == '0);
                    neg_q  <= s1 ^ s2;
                    neg_r  <= s1;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        if (!div_diff[WIDTH+1]) begin
                            w_hi <= div_diff[WIDTH-1:0];
                            w_lo <= {w_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            w_hi <= {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
                            w_lo <= {w_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {w_hi, w_lo} <= {mul_sum, w_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q   <= hi_fix;
                    lo_q   <= lo_fix;
                    zero_q <= ({hi_fix, lo_fix} == '0);
                    dbz_q  <= dbz;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
endmodule
